// File: rtl/pp_pkg.sv
// Shared types and constants for the path-parser front end.
// Holds the unpacker state encoding, default hop/RCI widths and the hop-index width helper.
// Imported by pp_hop_unpack and pp_hop_word_reg.
package pp_pkg;

  localparam int PP_HOP_NBITS     = 32;
  localparam int PP_HOPS_PER_WORD = 4;
  localparam int PP_RCI_NBITS     = 16;
  localparam int PP_HOP_CNT_NBITS = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UNPACK = 2'd1,
    FETCH  = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  // Bits needed to index the hops of one word (clog2, never below 1).
  function automatic int hop_idx_nbits(input int hops_per_word);
    int n = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < hops_per_word) n = i + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/pp_hop_word_reg.sv
// Holds the word currently being unpacked together with its eop flag.
// Latency: word visible the cycle after load; hop mux is combinational on idx.
// Backpressure: none; the unpacker decides when to load.
module pp_hop_word_reg
  import pp_pkg::*;
#(
  parameter int HOP_NBITS     = PP_HOP_NBITS,
  parameter int HOPS_PER_WORD = PP_HOPS_PER_WORD,
  parameter int IDX_NBITS     = hop_idx_nbits(HOPS_PER_WORD)
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               load,
  input  logic [HOPS_PER_WORD*HOP_NBITS-1:0] data,
  input  logic                               eop_in,
  input  logic [IDX_NBITS-1:0]               idx,
  output logic [HOP_NBITS-1:0]               hop,
  output logic                               eop
);

  logic [HOPS_PER_WORD*HOP_NBITS-1:0] word;

  // Capture a fresh input word and its eop flag when the unpacker accepts one.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      word <= '0;
      eop  <= 1'b0;
    end else if (load) begin
      word <= data;
      eop  <= eop_in;
    end
  end

  assign hop = word[int'(idx)*HOP_NBITS +: HOP_NBITS];

endmodule

// File: rtl/pp_hop_unpack.sv
// Unpacks packed path-header words into one hop per cycle for the parser's ping-pong hop FIFOs.
// Latency: FIFO reset + meta push in the sop accept cycle, first hop write next cycle, then 1 hop/cycle.
// Backpressure: pkt_ready low while unpacking or while the target slot is busy; writes pause on full.
// Optional statistics counters: define PP_HOP_UNPACK_STATS_EN.
module pp_hop_unpack
  import pp_pkg::*;
#(
  parameter int HOP_NBITS     = PP_HOP_NBITS,
  parameter int HOPS_PER_WORD = PP_HOPS_PER_WORD,
  parameter int RCI_NBITS     = PP_RCI_NBITS,
  parameter int HOP_CNT_NBITS = PP_HOP_CNT_NBITS
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               pkt_valid,
  output logic                               pkt_ready,
  input  logic                               pkt_sop,
  input  logic                               pkt_eop,
  input  logic [HOPS_PER_WORD*HOP_NBITS-1:0] pkt_data,
  input  logic [HOP_CNT_NBITS-1:0]           pkt_hop_cnt,
  input  logic [RCI_NBITS-1:0]               pkt_rci,
  output logic                               hop_fifo_reset0,
  output logic                               hop_fifo_reset1,
  output logic                               hop_fifo_wr0,
  output logic                               hop_fifo_wr1,
  output logic [HOP_NBITS-1:0]               hop_fifo_wdata0,
  output logic [HOP_NBITS-1:0]               hop_fifo_wdata1,
  input  logic                               hop_fifo_full0,
  input  logic                               hop_fifo_full1,
  input  logic                               parse_done0,
  input  logic                               parse_done1,
  output logic                               pp_meta_valid,
  output logic [RCI_NBITS-1:0]               pp_meta_rci,
  output logic                               err_trunc,
  output logic                               err_zero
`ifdef PP_HOP_UNPACK_STATS_EN
  ,
  output logic [31:0]                        stat_pkts,
  output logic [31:0]                        stat_hops,
  output logic [15:0]                        stat_errs
`endif
);

  localparam int                     IDX_NBITS = hop_idx_nbits(HOPS_PER_WORD);
  localparam logic [IDX_NBITS-1:0]   IDX_LAST  = IDX_NBITS'(HOPS_PER_WORD - 1);
  localparam logic [HOP_CNT_NBITS-1:0] CNT_ONE = HOP_CNT_NBITS'(1);

  state_t                   state, state_nxt;
  logic                     wptr, wptr_nxt;
  logic [1:0]               busy, busy_set;
  logic [IDX_NBITS-1:0]     idx, idx_nxt;
  logic [HOP_CNT_NBITS-1:0] hops_left, hops_left_nxt;
  logic                     word_load, word_eop;
  logic [HOP_NBITS-1:0]     word_hop;
  logic                     full_sel;
  logic                     rdy, wr, fifo_rst, meta, trunc, zero;

  pp_hop_word_reg #(
    .HOP_NBITS     (HOP_NBITS),
    .HOPS_PER_WORD (HOPS_PER_WORD),
    .IDX_NBITS     (IDX_NBITS)
  ) u_word (
    .clk    (clk),
    .rstn   (rstn),
    .load   (word_load),
    .data   (pkt_data),
    .eop_in (pkt_eop),
    .idx    (idx),
    .hop    (word_hop),
    .eop    (word_eop)
  );

  assign full_sel = wptr ? hop_fifo_full1 : hop_fifo_full0;

  // Next-state and per-cycle strobes; every strobe is forced low while rstn is asserted.
  always_comb begin
    state_nxt     = state;
    wptr_nxt      = wptr;
    idx_nxt       = idx;
    hops_left_nxt = hops_left;
    busy_set      = 2'b00;
    word_load     = 1'b0;
    rdy           = 1'b0;
    wr            = 1'b0;
    fifo_rst      = 1'b0;
    meta          = 1'b0;
    trunc         = 1'b0;
    zero          = 1'b0;
    case (state)
      IDLE: begin
        rdy = ~busy[wptr];
        if (pkt_valid && !busy[wptr] && pkt_sop) begin
          if (pkt_hop_cnt != '0) begin
            word_load      = 1'b1;
            idx_nxt        = '0;
            hops_left_nxt  = pkt_hop_cnt;
            fifo_rst       = 1'b1;
            meta           = 1'b1;
            busy_set[wptr] = 1'b1;
            state_nxt      = UNPACK;
          end else begin
            zero      = 1'b1;
            state_nxt = pkt_eop ? IDLE : DRAIN;
          end
        end
      end
      UNPACK: begin
        if (!full_sel) begin
          wr      = 1'b1;
          idx_nxt = idx + 1'b1;
          if (hops_left != '0) hops_left_nxt = hops_left - 1'b1;
          if (hops_left == CNT_ONE) begin
            // Slot is complete here even if trailing words still need draining,
            // so the next packet always lands in the other slot.
            wptr_nxt  = ~wptr;
            state_nxt = word_eop ? IDLE : DRAIN;
          end else if (idx == IDX_LAST) begin
            if (word_eop) begin
              trunc     = 1'b1;
              wptr_nxt  = ~wptr;
              state_nxt = IDLE;
            end else begin
              state_nxt = FETCH;
            end
          end
        end
      end
      FETCH: begin
        rdy = 1'b1;
        if (pkt_valid) begin
          if (pkt_sop) begin
            trunc     = 1'b1;
            wptr_nxt  = ~wptr;
            state_nxt = IDLE;
          end else begin
            word_load = 1'b1;
            idx_nxt   = '0;
            state_nxt = UNPACK;
          end
        end
      end
      DRAIN: begin
        rdy = 1'b1;
        if (pkt_valid && pkt_eop) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (!rstn) begin
      rdy       = 1'b0;
      wr        = 1'b0;
      fifo_rst  = 1'b0;
      meta      = 1'b0;
      trunc     = 1'b0;
      zero      = 1'b0;
      word_load = 1'b0;
      busy_set  = 2'b00;
    end
  end

  // State, write pointer, hop counters and slot-busy flags.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      wptr      <= 1'b0;
      idx       <= '0;
      hops_left <= '0;
      busy      <= 2'b00;
    end else begin
      state     <= state_nxt;
      wptr      <= wptr_nxt;
      idx       <= idx_nxt;
      hops_left <= hops_left_nxt;
      busy      <= (busy | busy_set) & ~{parse_done1, parse_done0};
    end
  end

  assign pkt_ready       = rdy;
  assign hop_fifo_reset0 = fifo_rst & ~wptr;
  assign hop_fifo_reset1 = fifo_rst & wptr;
  assign hop_fifo_wr0    = wr & ~wptr;
  assign hop_fifo_wr1    = wr & wptr;
  assign hop_fifo_wdata0 = word_hop;
  assign hop_fifo_wdata1 = word_hop;
  assign pp_meta_valid   = meta;
  assign pp_meta_rci     = meta ? pkt_rci : '0;
  assign err_trunc       = trunc;
  assign err_zero        = zero;

`ifdef PP_HOP_UNPACK_STATS_EN
  // Saturating event counters, updated the cycle after each event.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      stat_pkts <= '0;
      stat_hops <= '0;
      stat_errs <= '0;
    end else begin
      if (meta && stat_pkts != '1) stat_pkts <= stat_pkts + 32'd1;
      if (wr && stat_hops != '1) stat_hops <= stat_hops + 32'd1;
      if ((trunc || zero) && stat_errs != '1) stat_errs <= stat_errs + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pp_hop_unpack.sv
`timescale 1ns/1ps
module tb_pp_hop_unpack;
  localparam int HB  = 32;
  localparam int HPW = 4;
  localparam int RB  = 16;
  localparam int CB  = 8;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              pkt_valid = 1'b0, pkt_sop = 1'b0, pkt_eop = 1'b0;
  logic              pkt_ready;
  logic [HPW*HB-1:0] pkt_data = '0;
  logic [CB-1:0]     pkt_hop_cnt = '0;
  logic [RB-1:0]     pkt_rci = '0;
  logic              hop_fifo_reset0, hop_fifo_reset1, hop_fifo_wr0, hop_fifo_wr1;
  logic [HB-1:0]     hop_fifo_wdata0, hop_fifo_wdata1;
  logic              hop_fifo_full0 = 1'b0, hop_fifo_full1 = 1'b0;
  logic              parse_done0 = 1'b0, parse_done1 = 1'b0;
  logic              pp_meta_valid;
  logic [RB-1:0]     pp_meta_rci;
  logic              err_trunc, err_zero;

  pp_hop_unpack dut (
    .clk(clk), .rstn(rstn),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_sop(pkt_sop), .pkt_eop(pkt_eop),
    .pkt_data(pkt_data), .pkt_hop_cnt(pkt_hop_cnt), .pkt_rci(pkt_rci),
    .hop_fifo_reset0(hop_fifo_reset0), .hop_fifo_reset1(hop_fifo_reset1),
    .hop_fifo_wr0(hop_fifo_wr0), .hop_fifo_wr1(hop_fifo_wr1),
    .hop_fifo_wdata0(hop_fifo_wdata0), .hop_fifo_wdata1(hop_fifo_wdata1),
    .hop_fifo_full0(hop_fifo_full0), .hop_fifo_full1(hop_fifo_full1),
    .parse_done0(parse_done0), .parse_done1(parse_done1),
    .pp_meta_valid(pp_meta_valid), .pp_meta_rci(pp_meta_rci),
    .err_trunc(err_trunc), .err_zero(err_zero)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- output monitor (samples on the falling edge) ----------------
  int            cyc = 0;
  logic [HB-1:0] q0[$], q1[$];
  logic [RB-1:0] meta_q[$];
  int            wcyc[$];
  int            rst0_n, rst1_n, trunc_n, zero_n, rst_cyc, meta_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (hop_fifo_wr0) begin
      q0.push_back(hop_fifo_wdata0);
      wcyc.push_back(cyc);
      chk("wr0 while full0", hop_fifo_full0, 0);
      chk("wr0 with reset0", hop_fifo_reset0, 0);
    end
    if (hop_fifo_wr1) begin
      q1.push_back(hop_fifo_wdata1);
      wcyc.push_back(cyc);
      chk("wr1 while full1", hop_fifo_full1, 0);
      chk("wr1 with reset1", hop_fifo_reset1, 0);
    end
    if (hop_fifo_reset0) begin rst0_n++; rst_cyc = cyc; end
    if (hop_fifo_reset1) begin rst1_n++; rst_cyc = cyc; end
    if (pp_meta_valid) begin meta_q.push_back(pp_meta_rci); meta_cyc = cyc; end
    if (err_trunc) trunc_n++;
    if (err_zero) zero_n++;
  end

  task automatic clear_mon();
    q0.delete(); q1.delete(); meta_q.delete(); wcyc.delete();
    rst0_n = 0; rst1_n = 0; trunc_n = 0; zero_n = 0; rst_cyc = -1; meta_cyc = -2;
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic logic [HPW*HB-1:0] mk_word(input logic [31:0] base, input int w);
    logic [HPW*HB-1:0] d;
    d = '0;
    for (int k = 0; k < HPW; k++) d[k*HB +: HB] = base + 32'(w*HPW + k);
    return d;
  endfunction

  task automatic send_word(input logic sop, input logic eop, input logic [HPW*HB-1:0] d,
                           input logic [CB-1:0] cnt, input logic [RB-1:0] rci, input string tag);
    bit ok;
    ok = 0;
    pkt_valid = 1'b1; pkt_sop = sop; pkt_eop = eop; pkt_data = d;
    pkt_hop_cnt = cnt; pkt_rci = rci;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (pkt_ready) begin ok = 1; break; end
    end
    chk({tag, " word accepted"}, ok, 1);
    if (ok) @(posedge clk);
    #1;
    pkt_valid = 1'b0; pkt_sop = 1'b0; pkt_eop = 1'b0;
  endtask

  task automatic send_pkt(input int cnt, input int nw, input logic [RB-1:0] rci,
                          input logic [31:0] base, input string tag);
    for (int w = 0; w < nw; w++)
      send_word(w == 0, w == nw - 1, mk_word(base, w), CB'(cnt), rci, tag);
  endtask

  task automatic pulse_done(input int s);
    @(posedge clk); #1;
    if (s == 0) parse_done0 = 1'b1; else parse_done1 = 1'b1;
    @(posedge clk); #1;
    parse_done0 = 1'b0; parse_done1 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    int        cnt;
    int        nw;
    logic [RB-1:0] rci;
    int        exp_wr;
    int        exp_trunc;
    int        exp_zero;
    int        exp_meta;
  } vec_t;

  localparam int NV = 9;
  vec_t vec[NV];

  initial begin
    int            m;
    int            s;
    int            n_act;
    logic [31:0]   base;
    logic [HB-1:0] hv;
    string         tg;

    vec[0] = '{3, 1, 16'h0042, 3, 0, 0, 1};  // single word sop&eop
    vec[1] = '{6, 3, 16'h0101, 6, 0, 0, 1};  // two words of hops, third word drained
    vec[2] = '{8, 1, 16'h0202, 4, 1, 0, 1};  // eop before hop_cnt reached
    vec[3] = '{0, 1, 16'h0303, 0, 0, 1, 0};  // zero hops, sop&eop
    vec[4] = '{0, 3, 16'h0404, 0, 0, 1, 0};  // zero hops, rest drained
    vec[5] = '{4, 1, 16'h0505, 4, 0, 0, 1};  // exactly one full word
    vec[6] = '{5, 2, 16'h0606, 5, 0, 0, 1};  // crosses into second word
    vec[7] = '{8, 2, 16'h0707, 8, 0, 0, 1};  // exactly two full words
    vec[8] = '{9, 2, 16'h0808, 8, 1, 0, 1};  // truncated on second word
    clear_mon();

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset pkt_ready", pkt_ready, 0);
    chk("reset wr", {hop_fifo_wr0, hop_fifo_wr1}, 0);
    chk("reset fifo_reset", {hop_fifo_reset0, hop_fifo_reset1}, 0);
    chk("reset meta", {pp_meta_valid, pp_meta_rci}, 0);
    chk("reset errs", {err_trunc, err_zero}, 0);
    chk("reset wdata", hop_fifo_wdata0, 0);
    @(posedge clk); #1 rstn = 1'b1;
    @(negedge clk);
    chk("ready after reset", pkt_ready, 1);
    idle(1);

    m = 0;
    for (int v = 0; v < NV; v++) begin
      tg = $sformatf("v%0d", v);
      clear_mon();
      s = m;
      base = 32'((v + 1) << 16);
      send_pkt(vec[v].cnt, vec[v].nw, vec[v].rci, base, tg);
      idle(8);
      n_act = (s == 0) ? q0.size() : q1.size();
      chk({tg, " write count"}, n_act, vec[v].exp_wr);
      chk({tg, " other slot writes"}, (s == 0) ? q1.size() : q0.size(), 0);
      for (int i = 0; i < n_act && i < vec[v].exp_wr; i++) begin
        hv = (s == 0) ? q0[i] : q1[i];
        chk($sformatf("%s hop%0d", tg, i), hv, base + 32'(i));
      end
      chk({tg, " err_trunc"}, trunc_n, vec[v].exp_trunc);
      chk({tg, " err_zero"}, zero_n, vec[v].exp_zero);
      chk({tg, " meta count"}, meta_q.size(), vec[v].exp_meta);
      if (vec[v].exp_meta != 0 && meta_q.size() > 0) begin
        chk({tg, " meta rci"}, meta_q[0], vec[v].rci);
        chk({tg, " meta with reset"}, meta_cyc, rst_cyc);
      end
      chk({tg, " slot reset"}, (s == 0) ? rst0_n : rst1_n, vec[v].exp_meta);
      chk({tg, " other reset"}, (s == 0) ? rst1_n : rst0_n, 0);
      if (vec[v].exp_meta != 0) begin
        pulse_done(s);
        m ^= 1;
      end
    end

    // Cycle timing across a word boundary: one FETCH cycle between hop 3 and hop 4
    clear_mon();
    send_pkt(8, 2, 16'h0A0A, 32'h00A0_0000, "tim");
    idle(10);
    chk("tim writes", wcyc.size(), 8);
    if (wcyc.size() == 8) begin
      chk("tim first write after reset", wcyc[0] - rst_cyc, 1);
      chk("tim word0 back-to-back", wcyc[3] - wcyc[0], 3);
      chk("tim fetch gap", wcyc[4] - wcyc[3], 2);
      chk("tim word1 back-to-back", wcyc[7] - wcyc[4], 3);
    end
    pulse_done(m);
    m ^= 1;

    // Back-to-back packets with no parse_done, third one stalls
    clear_mon();
    s = m;
    send_pkt(2, 1, 16'h0C01, 32'h00C1_0000, "bb1");
    send_pkt(2, 1, 16'h0C02, 32'h00C2_0000, "bb2");
    pkt_valid = 1'b1; pkt_sop = 1'b1; pkt_eop = 1'b1;
    pkt_data = mk_word(32'h00C3_0000, 0); pkt_hop_cnt = 8'd2; pkt_rci = 16'h0C03;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("bb3 stall %0d", i), pkt_ready, 0);
    end
    @(posedge clk); #1;
    if (s == 0) parse_done0 = 1'b1; else parse_done1 = 1'b1;
    @(negedge clk);
    chk("bb3 ready in done cycle", pkt_ready, 0);
    @(posedge clk); #1;
    parse_done0 = 1'b0; parse_done1 = 1'b0;
    @(negedge clk);
    chk("bb3 ready after done", pkt_ready, 1);
    @(posedge clk); #1;
    pkt_valid = 1'b0; pkt_sop = 1'b0; pkt_eop = 1'b0;
    idle(6);
    chk("bb slot writes", (s == 0) ? q0.size() : q1.size(), 4);
    chk("bb other writes", (s == 0) ? q1.size() : q0.size(), 2);
    if (q0.size() + q1.size() == 6) begin
      chk("bb slot hop0", (s == 0) ? q0[0] : q1[0], 32'h00C1_0000);
      chk("bb slot hop3", (s == 0) ? q0[3] : q1[3], 32'h00C3_0001);
      chk("bb other hop1", (s == 0) ? q1[1] : q0[1], 32'h00C2_0001);
    end
    chk("bb slot resets", (s == 0) ? rst0_n : rst1_n, 2);
    chk("bb meta count", meta_q.size(), 3);
    if (meta_q.size() == 3) chk("bb meta order", {meta_q[0], meta_q[1], meta_q[2]}, 48'h0C01_0C02_0C03);
    m ^= 1;
    pulse_done(0);
    pulse_done(1);

    // Slot full held for 5 cycles mid-packet
    clear_mon();
    s = m;
    fork
      send_pkt(8, 2, 16'h0F0F, 32'h00F0_0000, "full");
      begin
        repeat (3) @(posedge clk);
        #1;
        if (s == 0) hop_fifo_full0 = 1'b1; else hop_fifo_full1 = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        hop_fifo_full0 = 1'b0; hop_fifo_full1 = 1'b0;
      end
    join
    idle(10);
    n_act = (s == 0) ? q0.size() : q1.size();
    chk("full write count", n_act, 8);
    for (int i = 0; i < n_act && i < 8; i++) begin
      hv = (s == 0) ? q0[i] : q1[i];
      chk($sformatf("full hop%0d", i), hv, 32'h00F0_0000 + 32'(i));
    end
    if (wcyc.size() == 8) chk("full span", wcyc[7] - wcyc[0], 13);
    pulse_done(s);
    m ^= 1;

    // Reset in the middle of UNPACK
    clear_mon();
    send_word(1'b1, 1'b1, mk_word(32'h00D0_0000, 0), 8'd8, 16'h0D0D, "rst");
    @(posedge clk); #1 rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst pkt_ready", pkt_ready, 0);
    chk("midrst wr", {hop_fifo_wr0, hop_fifo_wr1}, 0);
    chk("midrst fifo_reset", {hop_fifo_reset0, hop_fifo_reset1}, 0);
    chk("midrst meta", {pp_meta_valid, pp_meta_rci}, 0);
    chk("midrst errs", {err_trunc, err_zero}, 0);
    chk("midrst wdata", hop_fifo_wdata0, 0);
    @(posedge clk); #1 rstn = 1'b1;
    clear_mon();
    send_pkt(2, 1, 16'h0E0E, 32'h00E0_0000, "post");
    idle(6);
    chk("post slot0 writes", q0.size(), 2);
    chk("post slot1 writes", q1.size(), 0);
    chk("post slot0 reset", rst0_n, 1);
    if (q0.size() == 2) chk("post hop1", q0[1], 32'h00E0_0001);
    if (meta_q.size() == 1) chk("post meta rci", meta_q[0], 16'h0E0E);
    else chk("post meta count", meta_q.size(), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, expected finish before 500us");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
